// File: rtl/smc_ctrl.sv
// SMC front-end controller: loads six transistor beats, holds them for the
// SMC datapath for one compute cycle, then presents the result until it is taken.
module smc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_w,
  input  logic [2:0] in_vgs,
  input  logic [2:0] in_vds,
  input  logic [1:0] in_mode,
  output logic [2:0] W_0,
  output logic [2:0] W_1,
  output logic [2:0] W_2,
  output logic [2:0] W_3,
  output logic [2:0] W_4,
  output logic [2:0] W_5,
  output logic [2:0] V_GS_0,
  output logic [2:0] V_GS_1,
  output logic [2:0] V_GS_2,
  output logic [2:0] V_GS_3,
  output logic [2:0] V_GS_4,
  output logic [2:0] V_GS_5,
  output logic [2:0] V_DS_0,
  output logic [2:0] V_DS_1,
  output logic [2:0] V_DS_2,
  output logic [2:0] V_DS_3,
  output logic [2:0] V_DS_4,
  output logic [2:0] V_DS_5,
  output logic [1:0] mode,
  input  logic [7:0] out_n,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic [7:0] job_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg;
  logic [1:0]  mode_reg;
  logic [7:0]  result_reg;
  logic [7:0]  job_cnt_reg;
  logic [17:0] w_flat, vgs_flat, vds_flat;
  logic        accept, done;

  assign accept = in_valid & in_ready;
  assign done   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = LOAD;
      LOAD: if (accept && idx_reg == 3'd5) state_next = CALC;
      CALC: state_next = OUT;
      OUT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE) || (state_reg == LOAD);
    out_valid = (state_reg == OUT);
  end

  // idx stays 0 in IDLE, so beat 0 naturally targets slot 0
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg     <= 3'd0;
      mode_reg    <= 2'd0;
      result_reg  <= 8'd0;
      job_cnt_reg <= 8'd0;
    end else begin
      if (accept) idx_reg <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
      if (accept && state_reg == IDLE) mode_reg <= in_mode;
      if (state_reg == CALC) result_reg <= out_n;
      if (done) job_cnt_reg <= job_cnt_reg + 8'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_slot
      logic [2:0] w_reg, vgs_reg, vds_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          w_reg   <= 3'd0;
          vgs_reg <= 3'd0;
          vds_reg <= 3'd0;
        end else if (accept && idx_reg == 3'(gi)) begin
          w_reg   <= in_w;
          vgs_reg <= in_vgs;
          vds_reg <= in_vds;
        end
      end
      assign w_flat[gi*3 +: 3]   = w_reg;
      assign vgs_flat[gi*3 +: 3] = vgs_reg;
      assign vds_flat[gi*3 +: 3] = vds_reg;
    end
  endgenerate

  assign W_0 = w_flat[2:0];
  assign W_1 = w_flat[5:3];
  assign W_2 = w_flat[8:6];
  assign W_3 = w_flat[11:9];
  assign W_4 = w_flat[14:12];
  assign W_5 = w_flat[17:15];
  assign V_GS_0 = vgs_flat[2:0];
  assign V_GS_1 = vgs_flat[5:3];
  assign V_GS_2 = vgs_flat[8:6];
  assign V_GS_3 = vgs_flat[11:9];
  assign V_GS_4 = vgs_flat[14:12];
  assign V_GS_5 = vgs_flat[17:15];
  assign V_DS_0 = vds_flat[2:0];
  assign V_DS_1 = vds_flat[5:3];
  assign V_DS_2 = vds_flat[8:6];
  assign V_DS_3 = vds_flat[11:9];
  assign V_DS_4 = vds_flat[14:12];
  assign V_DS_5 = vds_flat[17:15];

  assign mode    = mode_reg;
  assign result  = result_reg;
  assign job_cnt = job_cnt_reg;

endmodule

// File: doc/smc_ctrl.md
SMC_CTRL -- requirements
Module: smc_ctrl

Interface
REQ-001 The block SHALL expose the following ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  one transistor beat is present on in_w / in_vgs / in_vds / in_mode.
- in_ready  output  1  block can accept a beat this cycle.
- in_w  input  3  W of current transistor.
- in_vgs  input  3  V_GS of current transistor.
- in_vds  input  3  V_DS of current transistor.
- in_mode  input  2  calculation mode; sampled on beat 0 only.
- W_0..W_5  output  3 each  registered W to the SMC datapath.
- V_GS_0..V_GS_5  output  3 each  registered V_GS to the SMC datapath.
- V_DS_0..V_DS_5  output  3 each  registered V_DS to the SMC datapath.
- mode  output  2  registered mode to the SMC datapath.
- out_n  input  8  combinational SMC result.
- out_valid  output  1  result holds a valid job result.
- out_ready  input  1  consumer accepts the result.
- result  output  8  captured out_n.
- job_cnt  output  8  number of completed jobs, wraps at 255->0.

Function
REQ-002 The block SHALL implement states IDLE, LOAD, CALC and OUT.
REQ-003 A beat SHALL be accepted only when in_valid=1 and in_ready=1 in the same cycle.
REQ-004 The block SHALL drive in_ready=1 in IDLE and LOAD, and 0 in CALC and OUT.
REQ-005 The block SHALL keep a 3-bit beat index idx (0..5) that selects which transistor register (W_idx, V_GS_idx, V_DS_idx) an accepted beat writes.
REQ-006 IDLE with an accepted beat SHALL:
- write transistor 0;
- latch in_mode into mode;
- set idx=1;
- go to LOAD.
REQ-007 LOAD with an accepted beat SHALL write transistor idx and increment idx.
REQ-008 When the accepted beat is idx=5, the block SHALL clear idx to 0 and go to CALC.
REQ-009 In IDLE or LOAD, a cycle with in_valid=0 SHALL leave idx and all registers unchanged, with no timeout.
REQ-010 in_mode on beats 1..5 SHALL be ignored.
REQ-011 CALC SHALL last exactly one cycle and SHALL capture out_n into result at the end of that cycle, then go to OUT.
REQ-012 OUT SHALL hold out_valid=1 and result stable until out_ready=1.
REQ-013 In the cycle out_valid=1 and out_ready=1, the block SHALL:
- increment job_cnt (modulo 256);
- go to IDLE.
REQ-014 out_valid SHALL be 0 in every state except OUT.
REQ-015 A new job's first beat SHALL NOT be accepted in the handshake cycle; in_ready SHALL rise the cycle after.
REQ-016 Latency: if beat 5 is accepted at edge T, result SHALL be captured at T+1 and out_valid SHALL be 1 in the cycle following edge T+1.
REQ-017 W_k, V_GS_k, V_DS_k and mode SHALL remain at their last-loaded values until overwritten by a later job; they are not cleared between jobs.
REQ-018 out_ready while out_valid=0 SHALL be ignored.
REQ-019 result SHALL hold its value outside OUT until the next CALC.

Reset
REQ-020 When rst=1 at a clock edge, in any state (including mid-LOAD, CALC or OUT), the block SHALL set:
- state=IDLE, idx=0;
- all W_k, V_GS_k, V_DS_k and mode = 0;
- result=0, job_cnt=0, out_valid=0.
REQ-021 While rst=1, in_ready SHALL be 1 (IDLE) but no beat SHALL be accepted.
REQ-022 Reset SHALL take precedence over every simultaneous handshake.

Verification
REQ-023 Back-to-back load:
- stimulus: 6 consecutive beats, mode=2, W/VGS/VDS = k+1 for transistor k; stub out_n = 8'hA5; out_ready held 1.
- response: out_valid 2 cycles after beat 5; result=8'hA5; job_cnt=1; W_3=V_GS_3=V_DS_3=4.
REQ-024 Stalled load:
- stimulus: beats with 3-cycle in_valid gaps between beats 2 and 3.
- response: idx holds at 3 during the gap; final registers are identical to the back-to-back case.
REQ-025 Output backpressure:
- stimulus: out_ready=0 for 10 cycles after out_valid, then 1.
- response: out_valid and result stable for all 10 cycles; in_ready=0 throughout; in_ready=1 one cycle after the handshake.
REQ-026 Reset mid-LOAD:
- stimulus: rst=1 after 4 beats.
- response: next cycle all outputs 0, state IDLE; the following 6 beats form a fresh job.
REQ-027 Mode sampling and counter wrap:
- stimulus: in_mode=1 on beat 0 and 3 on beats 1..5; then 256 completed jobs.
- response: mode=1; job_cnt returns to 0 after the 256th handshake.
